// File: rtl/alu_seq_pkg.sv
// Shared ALU opcode and branch-compare codes plus the request holding record for alu_seq.
package alu_seq_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;
   localparam int BROP_W = 3;

   localparam logic [OP_W-1:0] ALUOP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] ALUOP_SUB  = 5'd1;
   localparam logic [OP_W-1:0] ALUOP_AND  = 5'd2;
   localparam logic [OP_W-1:0] ALUOP_OR   = 5'd3;
   localparam logic [OP_W-1:0] ALUOP_XOR  = 5'd4;
   localparam logic [OP_W-1:0] ALUOP_SLL  = 5'd5;
   localparam logic [OP_W-1:0] ALUOP_SRL  = 5'd6;
   localparam logic [OP_W-1:0] ALUOP_SRA  = 5'd7;
   localparam logic [OP_W-1:0] ALUOP_SLT  = 5'd8;
   localparam logic [OP_W-1:0] ALUOP_SLTU = 5'd9;

   localparam logic [BROP_W-1:0] BROP_BEQ  = 3'd0;
   localparam logic [BROP_W-1:0] BROP_BNE  = 3'd1;
   localparam logic [BROP_W-1:0] BROP_BLT  = 3'd4;
   localparam logic [BROP_W-1:0] BROP_BGE  = 3'd5;
   localparam logic [BROP_W-1:0] BROP_BLTU = 3'd6;
   localparam logic [BROP_W-1:0] BROP_BGEU = 3'd7;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [BROP_W-1:0] brop;
   } alu_req_t;

endpackage

// File: rtl/alu_seq_branch_eval.sv
// Branch decision from the ALU compare flags of a SUB.
module branch_eval
   import alu_seq_pkg::*;
(
   input  logic [BROP_W-1:0] brop,
   input  logic              lt,
   input  logic              ltu,
   input  logic              eq,
   output logic              taken
);

   always_comb begin
      taken = 1'b0;
      case (brop)
         BROP_BEQ:  taken = eq;
         BROP_BNE:  taken = !eq;
         BROP_BLT:  taken = lt;
         BROP_BGE:  taken = !lt;
         BROP_BLTU: taken = ltu;
         BROP_BGEU: taken = !ltu;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Issue sequencer for the alu execute unit: request latch, I_en/O_busy handshake, registered response.
// Define ALU_SEQ_BRANCH_EN to compute O_rsp_taken from the compare flags; otherwise it is tied 0.
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic              I_clk,
   input  logic              I_reset_n,
   input  logic              I_flush,
   input  logic              I_req_valid,
   output logic              O_req_ready,
   input  logic [OP_W-1:0]   I_req_op,
   input  logic [DATA_W-1:0] I_req_a,
   input  logic [DATA_W-1:0] I_req_b,
   input  logic [BROP_W-1:0] I_req_brop,
   output logic              O_rsp_valid,
   input  logic              I_rsp_ready,
   output logic [DATA_W-1:0] O_rsp_data,
   output logic              O_rsp_taken,
   output logic              O_alu_reset,
   output logic              O_alu_en,
   output logic [OP_W-1:0]   O_alu_op,
   output logic [DATA_W-1:0] O_alu_s1,
   output logic [DATA_W-1:0] O_alu_s2,
   input  logic              I_alu_busy,
   input  logic [DATA_W-1:0] I_alu_data,
   input  logic              I_alu_lt,
   input  logic              I_alu_ltu,
   input  logic              I_alu_eq
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   alu_req_t          hold_q;
   logic              drop_q, drop_d;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_taken_q;
   logic              taken_c;
   logic              accept, capture;

`ifdef ALU_SEQ_BRANCH_EN
   branch_eval u_branch_eval (
      .brop  (hold_q.brop),
      .lt    (I_alu_lt),
      .ltu   (I_alu_ltu),
      .eq    (I_alu_eq),
      .taken (taken_c)
   );
`else
   logic unused_branch;
   assign unused_branch = ^{I_req_brop, hold_q.brop, I_alu_lt, I_alu_ltu, I_alu_eq};
   assign taken_c = 1'b0;
`endif

   // Enables are gated by reset so the ALU never sees I_en while it is being cleared.
   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      accept      = 1'b0;
      capture     = 1'b0;
      O_req_ready = 1'b0;
      O_alu_en    = 1'b0;
      O_rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            O_req_ready = I_reset_n && !I_flush;
            if (I_req_valid && !I_flush) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            O_alu_en = I_reset_n;
            if (I_flush) drop_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            O_alu_en = I_reset_n && I_alu_busy;
            if (I_flush) drop_d = 1'b1;
            if (!I_alu_busy) begin
               drop_d = 1'b0;
               if (drop_q || I_flush) begin
                  state_d = S_IDLE;
               end else begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            O_rsp_valid = 1'b1;
            if (I_flush || I_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (!I_reset_n) begin
         state_q     <= S_IDLE;
         drop_q      <= 1'b0;
         hold_q      <= '0;
         rsp_data_q  <= '0;
         rsp_taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (accept) begin
            hold_q.op   <= I_req_op;
            hold_q.a    <= I_req_a;
            hold_q.b    <= I_req_b;
            hold_q.brop <= I_req_brop;
         end
         if (capture) begin
            rsp_data_q  <= I_alu_data;
            rsp_taken_q <= taken_c;
         end
      end
   end

   assign O_alu_reset = !I_reset_n;
   assign O_alu_op    = hold_q.op;
   assign O_alu_s1    = hold_q.a;
   assign O_alu_s2    = hold_q.b;
   assign O_rsp_data  = rsp_data_q;
   assign O_rsp_taken = rsp_taken_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural multi-cycle ALU, directed ops, queue scoreboard with a separate monitor.
module tb_alu_seq;
   import alu_seq_pkg::*;

`ifdef ALU_SEQ_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   logic        I_clk = 1'b0;
   logic        I_reset_n = 1'b0;
   logic        I_flush = 1'b0;
   logic        I_req_valid = 1'b0;
   logic        O_req_ready;
   logic [4:0]  I_req_op = '0;
   logic [31:0] I_req_a = '0, I_req_b = '0;
   logic [2:0]  I_req_brop = '0;
   logic        O_rsp_valid;
   logic        I_rsp_ready = 1'b1;
   logic [31:0] O_rsp_data;
   logic        O_rsp_taken;
   logic        O_alu_reset, O_alu_en;
   logic [4:0]  O_alu_op;
   logic [31:0] O_alu_s1, O_alu_s2;
   logic        alu_busy = 1'b0;
   logic [31:0] alu_data = '0;
   logic        alu_lt = 1'b0, alu_ltu = 1'b0, alu_eq = 1'b0;

   alu_seq dut (
      .I_clk(I_clk), .I_reset_n(I_reset_n), .I_flush(I_flush),
      .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
      .I_req_op(I_req_op), .I_req_a(I_req_a), .I_req_b(I_req_b), .I_req_brop(I_req_brop),
      .O_rsp_valid(O_rsp_valid), .I_rsp_ready(I_rsp_ready),
      .O_rsp_data(O_rsp_data), .O_rsp_taken(O_rsp_taken),
      .O_alu_reset(O_alu_reset), .O_alu_en(O_alu_en), .O_alu_op(O_alu_op),
      .O_alu_s1(O_alu_s1), .O_alu_s2(O_alu_s2),
      .I_alu_busy(alu_busy), .I_alu_data(alu_data),
      .I_alu_lt(alu_lt), .I_alu_ltu(alu_ltu), .I_alu_eq(alu_eq)
   );

   always #5 I_clk = ~I_clk;

   // Reference ALU: shifts take one busy cycle per bit plus one; an enable while idle starts a new op.
   logic [4:0] sh_cnt = '0;
   logic [4:0] sh_op = '0;
   int         alu_starts = 0;
   always @(posedge I_clk) begin
      if (O_alu_reset) begin
         alu_busy <= 1'b0;
         sh_cnt   <= '0;
         alu_data <= '0;
      end else if (alu_busy) begin
         if (sh_cnt == 5'd0) alu_busy <= 1'b0;
         else begin
            sh_cnt <= sh_cnt - 5'd1;
            case (sh_op)
               ALUOP_SLL: alu_data <= alu_data << 1;
               ALUOP_SRL: alu_data <= alu_data >> 1;
               default:   alu_data <= $unsigned($signed(alu_data) >>> 1);
            endcase
         end
      end else if (O_alu_en) begin
         alu_starts <= alu_starts + 1;
         alu_lt  <= $signed(O_alu_s1) < $signed(O_alu_s2);
         alu_ltu <= O_alu_s1 < O_alu_s2;
         alu_eq  <= O_alu_s1 == O_alu_s2;
         case (O_alu_op)
            ALUOP_ADD: alu_data <= O_alu_s1 + O_alu_s2;
            ALUOP_SUB: alu_data <= O_alu_s1 - O_alu_s2;
            ALUOP_AND: alu_data <= O_alu_s1 & O_alu_s2;
            ALUOP_OR:  alu_data <= O_alu_s1 | O_alu_s2;
            ALUOP_XOR: alu_data <= O_alu_s1 ^ O_alu_s2;
            ALUOP_SLL, ALUOP_SRL, ALUOP_SRA: begin
               alu_data <= O_alu_s1;
               sh_cnt   <= O_alu_s2[4:0];
               sh_op    <= O_alu_op;
               alu_busy <= 1'b1;
            end
            default: alu_data <= '0;
         endcase
      end
   end

   typedef struct { logic [31:0] d; logic t; } exp_t;
   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every completed response handshake pops one expectation.
   initial forever begin
      @(negedge I_clk);
      if (I_reset_n && O_rsp_valid && I_rsp_ready) begin
         if (sb.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", O_rsp_data, e.d);
            chk("rsp_taken", {31'd0, O_rsp_taken}, {31'd0, e.t});
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] brop, input bit push, input logic [31:0] ed, input logic et);
      int k;
      k = 0;
      while (!O_req_ready && k < 50) begin @(posedge I_clk); #1; k++; end
      if (k >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
      I_req_valid = 1'b1; I_req_op = op; I_req_a = a; I_req_b = b; I_req_brop = brop;
      if (push) sb.push_back('{ed, et});
      @(posedge I_clk); #1;
      I_req_valid = 1'b0;
   endtask

   // Called just after the accept edge; lat is the cycle index in which O_rsp_valid first shows.
   task automatic wait_rsp(output int lat, output int en_cnt);
      lat = 0; en_cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge I_clk);
         if (O_alu_en) en_cnt++;
         if (O_rsp_valid) begin lat = k; break; end
      end
      if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
      @(posedge I_clk); #1;
   endtask

   task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] brop, input logic [31:0] ed, input logic et,
                         input int exp_lat, input int exp_en);
      int lat, en, s0;
      s0 = alu_starts;
      issue(op, a, b, brop, 1'b1, ed, et);
      wait_rsp(lat, en);
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_en_cycles"}, en, exp_en);
      chk({nm, "_alu_starts"}, alu_starts - s0, 32'd1);
   endtask

   initial begin
      int k, en, mism, s0;
      logic [31:0] held;

      repeat (2) @(posedge I_clk);
      #1;
      @(negedge I_clk);
      chk("rst_req_ready", {31'd0, O_req_ready}, 32'd0);
      chk("rst_alu_reset", {31'd0, O_alu_reset}, 32'd1);
      chk("rst_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
      chk("rst_rsp_data", O_rsp_data, 32'd0);
      chk("rst_alu_en", {31'd0, O_alu_en}, 32'd0);
      chk("rst_alu_s1", O_alu_s1, 32'd0);
      @(posedge I_clk); #1;
      I_reset_n = 1'b1;
      @(negedge I_clk);
      chk("post_rst_req_ready", {31'd0, O_req_ready}, 32'd1);
      @(posedge I_clk); #1;

      run_op("add", ALUOP_ADD, 32'd5, 32'd7, BROP_BEQ, 32'd12, 1'b0, 3, 1);
      run_op("sll31", ALUOP_SLL, 32'd1, 32'd31, BROP_BEQ, 32'h8000_0000, 1'b0, 35, 33);
      run_op("blt", ALUOP_SUB, 32'hFFFF_FFFF, 32'd1, BROP_BLT, 32'hFFFF_FFFE, BR_EN, 3, 1);
      run_op("bltu", ALUOP_SUB, 32'hFFFF_FFFF, 32'd1, BROP_BLTU, 32'hFFFF_FFFE, 1'b0, 3, 1);
      run_op("beq", ALUOP_SUB, 32'd3, 32'd3, BROP_BEQ, 32'd0, BR_EN, 3, 1);

      // Response backpressure: held for 5 cycles, accepted on the 6th.
      I_rsp_ready = 1'b0;
      issue(ALUOP_ADD, 32'd3, 32'd4, BROP_BEQ, 1'b1, 32'd7, 1'b0);
      k = 0;
      while (!O_rsp_valid && k < 20) begin @(posedge I_clk); #1; k++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge I_clk);
         chk("bp_rsp_valid", {31'd0, O_rsp_valid}, 32'd1);
         chk("bp_rsp_data", O_rsp_data, 32'd7);
         chk("bp_req_ready", {31'd0, O_req_ready}, 32'd0);
         @(posedge I_clk); #1;
      end
      I_rsp_ready = 1'b1;
      @(posedge I_clk); #1;
      @(negedge I_clk);
      chk("bp_back_idle", {31'd0, O_req_ready}, 32'd1);
      chk("bp_valid_dropped", {31'd0, O_rsp_valid}, 32'd0);
      @(posedge I_clk); #1;

      // Flush in IDLE blocks the request.
      I_req_valid = 1'b1; I_flush = 1'b1; I_req_op = ALUOP_ADD;
      @(negedge I_clk);
      chk("flush_idle_ready", {31'd0, O_req_ready}, 32'd0);
      @(posedge I_clk); #1;
      I_req_valid = 1'b0; I_flush = 1'b0;
      @(negedge I_clk);
      chk("flush_idle_no_issue", {31'd0, O_alu_en}, 32'd0);
      chk("flush_idle_ready_after", {31'd0, O_req_ready}, 32'd1);
      @(posedge I_clk); #1;

      // Flush in cycle 4 of SRA by 10: enable tracks busy, then back to idle without a response.
      s0 = alu_starts;
      issue(ALUOP_SRA, 32'h8000_0000, 32'd10, BROP_BEQ, 1'b0, 32'd0, 1'b0);
      en = 0; mism = 0;
      for (k = 1; k <= 40; k++) begin
         I_flush = (k == 4);
         @(negedge I_clk);
         if (O_alu_en) en++;
         if (k >= 2 && O_alu_en !== alu_busy) mism++;
         if (O_req_ready) break;
         @(posedge I_clk); #1;
      end
      I_flush = 1'b0;
      chk("flush_idle_cycle", k, 32'd14);
      chk("flush_en_cycles", en, 32'd12);
      chk("flush_en_tracks_busy", mism, 32'd0);
      chk("flush_alu_starts", alu_starts - s0, 32'd1);
      @(posedge I_clk); #1;
      run_op("add_after_flush", ALUOP_ADD, 32'd1, 32'd1, BROP_BEQ, 32'd2, 1'b0, 3, 1);

      // Reset in the middle of a shift.
      issue(ALUOP_SLL, 32'd1, 32'd20, BROP_BEQ, 1'b0, 32'd0, 1'b0);
      repeat (5) begin @(posedge I_clk); #1; end
      I_reset_n = 1'b0;
      @(negedge I_clk);
      chk("midrst_alu_reset", {31'd0, O_alu_reset}, 32'd1);
      chk("midrst_alu_en", {31'd0, O_alu_en}, 32'd0);
      chk("midrst_req_ready", {31'd0, O_req_ready}, 32'd0);
      @(posedge I_clk); #1;
      @(negedge I_clk);
      chk("midrst_alu_busy", {31'd0, alu_busy}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, O_rsp_valid}, 32'd0);
      chk("midrst_rsp_data", O_rsp_data, 32'd0);
      chk("midrst_alu_op", {27'd0, O_alu_op}, 32'd0);
      chk("midrst_alu_s2", O_alu_s2, 32'd0);
      @(posedge I_clk); #1;
      I_reset_n = 1'b1;
      @(negedge I_clk);
      chk("midrst_ready_after", {31'd0, O_req_ready}, 32'd1);
      @(posedge I_clk); #1;
      run_op("xor_after_reset", ALUOP_XOR, 32'hF0, 32'hFF, BROP_BEQ, 32'h0F, 1'b0, 3, 1);

      repeat (3) @(posedge I_clk);
      held = sb.size();
      chk("scoreboard_drained", held, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
